channel_llr_framer: RTL

CHANNEL_LLR_FRAMER -- requirements
Module: channel_llr_framer

---
 rtl/channel_llr_framer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/channel_llr_framer.sv
// Serial channel-LLR framer: converts two's-complement LLRs to saturated
// sign-magnitude, packs them into ping-pong frame banks and hands full
// frames to a decoder with a valid/busy/done handshake.
module channel_llr_framer #(
    parameter int n     = 5,
    parameter int Q     = 6,
    parameter int W     = 8,
    parameter int SHIFT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [W-1:0]          in_llr,
    output logic                  in_ready,
    input  logic                  decoder_busy,
    input  logic                  decoder_done,
    output logic [(2**n)*Q-1:0]   frame_out,
    output logic                  frame_valid,
    output logic [15:0]           sat_cnt
);

    localparam int unsigned N       = 2**n;
    localparam int unsigned MW      = Q - 1;
    localparam int unsigned MAG_MAX = 2**(Q-1) - 1;
    localparam int unsigned FW      = N * Q;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t         state;
    logic [1:0]     full;
    logic           wr_bank;
    logic           rd_bank;
    logic [n-1:0]   idx;
    logic [FW-1:0]  bank [2];

    logic [W-1:0]   mag;
    logic [W-1:0]   mag_sh;
    logic           sat;
    logic [Q-1:0]   conv;
    logic           accept;
    logic           release_bank;

    // Magnitude, scaling and clamp of the incoming sample; the sign survives a zero magnitude
    always_comb begin
        mag    = in_llr[W-1] ? (~in_llr + W'(1)) : in_llr;
        mag_sh = mag >> SHIFT;
        sat    = mag_sh > W'(MAG_MAX);
        conv   = {in_llr[W-1], sat ? MW'(MAG_MAX) : mag_sh[MW-1:0]};
    end

    assign in_ready     = !full[wr_bank];
    assign accept       = in_valid && in_ready;
    assign release_bank = ((state == WAIT_BUSY) || (state == WAIT_DONE)) && decoder_done;
    assign frame_out    = bank[rd_bank];

    // Bank pointers, full flags, write index and saturation counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            idx     <= '0;
            sat_cnt <= 16'd0;
        end else begin
            if (accept) begin
                if (idx == n'(N - 1)) begin
                    idx           <= '0;
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end else begin
                    idx <= idx + n'(1);
                end
                if (sat && (sat_cnt != 16'hFFFF)) begin
                    sat_cnt <= sat_cnt + 16'd1;
                end
            end
            // The released bank is never the one being written, so both updates can land together
            if (release_bank) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

    // Sample storage; contents are don't-care until a frame has been written
    always_ff @(posedge clk) begin
        if (accept) begin
            bank[wr_bank][idx*Q +: Q] <= conv;
        end
    end

    // Read-side handshake with the decoder; frame_valid is high only while in ISSUE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (full[rd_bank] && !decoder_busy) begin
                        state       <= ISSUE;
                        frame_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (decoder_done) begin
                        state <= IDLE;
                    end else if (decoder_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (decoder_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
